// File: rtl/booth_mult_seq.sv
// -----------------------------------------------------------------------------
// booth_mult_seq
// Sequential Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, one recoding step per
// clock through a single adder. Operands are interpreted as two's complement
// (signed_mode=1) or unsigned (signed_mode=0). Either way they are extended to
// an internal width E, and the same signed Booth datapath is used.
//
// Build option:
//   BOOTH_RADIX4_EN  defined   -> radix-4 recoding, E even, N = E/2 steps
//                    undefined -> radix-2 recoding, E = WIDTH+1, N = WIDTH+1
//   Results are identical in both builds; only latency differs.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   start        multiply request, accepted only in IDLE
//   signed_mode  operand interpretation, sampled with start
//   a_in, b_in   multiplicand / multiplier, sampled with start
//   busy         high in RUN and DONE
//   done         one-cycle pulse, prod valid in that cycle
//   prod         low 2*WIDTH bits of the product, held until the next result
// -----------------------------------------------------------------------------
module booth_mult_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] prod
);

`ifdef BOOTH_RADIX4_EN
   localparam int E = ((WIDTH % 2) == 0) ? (WIDTH + 2) : (WIDTH + 3);
   localparam int N = E / 2;
`else
   localparam int E = WIDTH + 1;
   localparam int N = WIDTH + 1;
`endif
   // One guard bit in the accumulator so that adding +/-2M cannot overflow.
   localparam int AW = E + 1;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(N);
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

`ifdef BOOTH_RADIX4_EN
   // Radix-4 partial product selected by the triplet {q1, q0, q-1}.
   function automatic logic [AW-1:0] booth_term(input logic [2:0] trip,
                                                input logic [E-1:0] m);
      logic [AW-1:0] m1;
      logic [AW-1:0] m2;
      m1 = {m[E-1], m};
      // m has at least two redundant sign bits, so a plain left shift is 2M.
      m2 = {m, 1'b0};
      case (trip)
         3'b001, 3'b010: booth_term = m1;
         3'b011:         booth_term = m2;
         3'b100:         booth_term = -m2;
         3'b101, 3'b110: booth_term = -m1;
         default:        booth_term = {AW{1'b0}};
      endcase
   endfunction
`else
   // Radix-2 partial product selected by the pair {q0, q-1}.
   function automatic logic [AW-1:0] booth_term(input logic [1:0] pair,
                                                input logic [E-1:0] m);
      logic [AW-1:0] m1;
      m1 = {m[E-1], m};
      case (pair)
         2'b01:   booth_term = m1;
         2'b10:   booth_term = -m1;
         default: booth_term = {AW{1'b0}};
      endcase
   endfunction
`endif

   state_t               state_q, state_d;
   logic [AW-1:0]        acc_q, acc_d;
   logic [E-1:0]         q_q, q_d;
   logic                 qm1_q, qm1_d;
   logic [E-1:0]         m_q, m_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;

   logic [AW-1:0]        sum_s;
   logic [AW+E-1:0]      full_s;
   logic [E-1:0]         a_ext_s;
   logic [E-1:0]         b_ext_s;
   logic                 unused_s;

   assign busy = busy_q;
   assign done = done_q;
   assign prod = prod_q;

   // {acc, Q} holds the exact product once all steps are done; only the low
   // 2*WIDTH bits are meaningful.
   assign full_s   = {acc_q, q_q};
   assign unused_s = ^full_s[AW+E-1:2*WIDTH];

   // Operand extension: after this both modes are plain signed arithmetic.
   assign a_ext_s = signed_mode ? {{(E-WIDTH){a_in[WIDTH-1]}}, a_in}
                                : {{(E-WIDTH){1'b0}}, a_in};
   assign b_ext_s = signed_mode ? {{(E-WIDTH){b_in[WIDTH-1]}}, b_in}
                                : {{(E-WIDTH){1'b0}}, b_in};

   // Next-state logic: handshake FSM plus one Booth step per RUN cycle.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      q_d     = q_q;
      qm1_d   = qm1_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      prod_d  = prod_q;
`ifdef BOOTH_RADIX4_EN
      sum_s   = acc_q + booth_term({q_q[1], q_q[0], qm1_q}, m_q);
`else
      sum_s   = acc_q + booth_term({q_q[0], qm1_q}, m_q);
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d   = {AW{1'b0}};
               q_d     = b_ext_s;
               qm1_d   = 1'b0;
               m_d     = a_ext_s;
               cnt_d   = CNT_LOAD;
               busy_d  = 1'b1;
               state_d = S_RUN;
            end else begin
               busy_d  = 1'b0;
            end
         end
         S_RUN: begin
            if (cnt_q == CNT_ZERO) begin
               prod_d  = full_s[2*WIDTH-1:0];
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               // Arithmetic right shift of {acc, Q, q-1} after the add.
`ifdef BOOTH_RADIX4_EN
               acc_d = {{2{sum_s[AW-1]}}, sum_s[AW-1:2]};
               q_d   = {sum_s[1:0], q_q[E-1:2]};
               qm1_d = q_q[1];
`else
               acc_d = {sum_s[AW-1], sum_s[AW-1:1]};
               q_d   = {sum_s[0], q_q[E-1:1]};
               qm1_d = q_q[0];
`endif
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         acc_q   <= {AW{1'b0}};
         q_q     <= {E{1'b0}};
         qm1_q   <= 1'b0;
         m_q     <= {E{1'b0}};
         cnt_q   <= CNT_ZERO;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         prod_q  <= {(2*WIDTH){1'b0}};
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         qm1_q   <= qm1_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         prod_q  <= prod_d;
      end
   end

endmodule

// File: tb/tb_booth_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_booth_mult_seq
// Self-checking bench for booth_mult_seq: a WIDTH=8 instance for directed,
// handshake, reset and random cases, and a WIDTH=5 instance for odd-width
// random cases running alongside. Expected products come from plain integer
// multiplication of the interpreted operands.
// -----------------------------------------------------------------------------
module tb_booth_mult_seq;

`ifdef BOOTH_RADIX4_EN
   localparam int N8 = 5;
   localparam int N5 = 4;
`else
   localparam int N8 = 9;
   localparam int N5 = 6;
`endif
   localparam int NRAND = 3000;

   logic        clk;
   logic        rst_n;
   logic        start, signed_mode;
   logic [7:0]  a_in, b_in;
   logic        busy, done;
   logic [15:0] prod;

   logic        start5, signed_mode5;
   logic [4:0]  a5, b5;
   logic        busy5, done5;
   logic [9:0]  prod5;

   int checks = 0;
   int errors = 0;
   int pend   = 0;

   booth_mult_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
      .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .prod(prod)
   );

   booth_mult_seq #(.WIDTH(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .start(start5), .signed_mode(signed_mode5),
      .a_in(a5), .b_in(b5), .busy(busy5), .done(done5), .prod(prod5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
      longint pa, pb, p;
      pa = s ? longint'($signed(a)) : longint'(a);
      pb = s ? longint'($signed(b)) : longint'(b);
      p  = pa * pb;
      return p[15:0];
   endfunction

   function automatic logic [9:0] ref5(input logic [4:0] a, input logic [4:0] b, input logic s);
      longint pa, pb, p;
      pa = s ? longint'($signed(a)) : longint'(a);
      pb = s ? longint'($signed(b)) : longint'(b);
      p  = pa * pb;
      return p[9:0];
   endfunction

   // Accept tracker for the WIDTH=8 instance: busy low means IDLE.
   always @(posedge clk) begin
      if (!rst_n) pend = 0;
      else if (start && !busy) pend = pend + 1;
   end

   // Every done pulse must be matched by an earlier accept.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         check("done_has_accept", (pend > 0), 1);
         if (pend > 0) pend = pend - 1;
      end
   end

   // One multiply on the WIDTH=8 instance; operands are scrambled mid-RUN.
   task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [15:0] exp_p);
      int k;
      @(negedge clk);
      a_in = a; b_in = b; signed_mode = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a_in = 8'($urandom); b_in = 8'($urandom); signed_mode = 1'($urandom);
      check({tag, "/busy"}, busy, 1);
      k = 0;
      while (done !== 1'b1 && k < 60) begin
         @(posedge clk); #1;
         k++;
      end
      check({tag, "/lat"}, k, N8 + 1);
      check({tag, "/prod"}, prod, exp_p);
      @(posedge clk); #1;
      check({tag, "/idle_busy"}, busy, 0);
      check({tag, "/idle_done"}, done, 0);
      check({tag, "/held"}, prod, exp_p);
   endtask

   // One multiply on the WIDTH=5 instance.
   task automatic run_mul5(input logic [4:0] a, input logic [4:0] b, input logic s);
      int k;
      logic [9:0] exp_p;
      exp_p = ref5(a, b, s);
      @(negedge clk);
      a5 = a; b5 = b; signed_mode5 = s; start5 = 1'b1;
      @(posedge clk); #1;
      start5 = 1'b0;
      a5 = 5'($urandom);
      k = 0;
      while (done5 !== 1'b1 && k < 60) begin
         @(posedge clk); #1;
         k++;
      end
      check("w5/lat", k, N5 + 1);
      check("w5/prod", prod5, exp_p);
      @(posedge clk); #1;
   endtask

   task automatic rand8();
      logic [7:0] a, b;
      logic s;
      for (int i = 0; i < NRAND; i++) begin
         a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
         run_mul("rand8", a, b, s, ref8(a, b, s));
      end
   endtask

   task automatic rand5();
      for (int i = 0; i < NRAND; i++)
         run_mul5(5'($urandom), 5'($urandom), 1'($urandom));
   endtask

   initial begin
      int cyc, last, nd;
      rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a_in = 8'h00; b_in = 8'h00;
      start5 = 1'b0; signed_mode5 = 1'b0; a5 = 5'h00; b5 = 5'h00;
      repeat (3) @(posedge clk);
      #1;
      check("rst/busy", busy, 0);
      check("rst/done", done, 0);
      check("rst/prod", prod, 0);
      check("rst/prod5", prod5, 0);
      @(negedge clk); rst_n = 1'b1;

      // Directed corner values with independently known results.
      run_mul("umax",  8'hFF, 8'hFF, 1'b0, 16'hFE01);
      run_mul("smin2", 8'h80, 8'h80, 1'b1, 16'h4000);
      run_mul("sminmax", 8'h80, 8'h7F, 1'b1, 16'hC080);
      run_mul("mix_s", 8'hFD, 8'h05, 1'b1, 16'hFFF1);
      run_mul("mix_u", 8'hFD, 8'h05, 1'b0, 16'h04F1);
      run_mul("zero",  8'h00, 8'h9C, 1'b1, 16'h0000);

      // start held high: one result every N+3 cycles.
      @(negedge clk);
      a_in = 8'd7; b_in = 8'd6; signed_mode = 1'b0; start = 1'b1;
      cyc = 0; last = -1; nd = 0;
      while (nd < 3 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (done === 1'b1) begin
            check("hold/prod", prod, 16'h002A);
            if (last >= 0) check("hold/period", cyc - last, N8 + 3);
            last = cyc;
            nd++;
         end
      end
      start = 1'b0;
      check("hold/count", nd, 3);
      repeat (N8 + 4) @(negedge clk);
      check("hold/quiet", busy, 0);

      // Reset four cycles into RUN discards the operation.
      @(negedge clk);
      a_in = 8'h12; b_in = 8'h34; signed_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1;
      check("midrst/busy", busy, 0);
      check("midrst/done", done, 0);
      check("midrst/prod", prod, 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (N8 + 3) @(negedge clk);
      check("midrst/nodone", done, 0);
      run_mul("after_rst", 8'd3, 8'd3, 1'b0, 16'h0009);

      // start coinciding with reset is not accepted.
      @(negedge clk);
      rst_n = 1'b0; start = 1'b1; a_in = 8'd5; b_in = 8'd5;
      @(posedge clk); #1;
      check("rststart/busy", busy, 0);
      @(negedge clk); start = 1'b0; rst_n = 1'b1;
      @(posedge clk); #1;
      check("rststart/busy2", busy, 0);

      // Random regression on both widths concurrently.
      fork
         rand8();
         rand5();
      join

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
